// File: rtl/code_conv_pkg.sv
// Shared encodings and elaboration-time helpers for the code conversion engine.
package code_conv_pkg;

  typedef enum logic [1:0] {
    MODE_GRAY = 2'b00,
    MODE_BCD  = 2'b01,
    MODE_XS3  = 2'b10,
    MODE_G2B  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CONV = 2'b01,
    ADJ  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((longint'(1) << r) < longint'(n)) r = r + 1;
    return r;
  endfunction

  // Smallest digit count whose decimal range covers 2^w-1.
  function automatic int bcd_digits(input int w);
    longint unsigned maxv;
    longint unsigned p;
    int nd;
    maxv = (64'd1 << w) - 64'd1;
    p    = 64'd10;
    nd   = 1;
    while (p <= maxv) begin
      p  = p * 64'd10;
      nd = nd + 1;
    end
    return nd;
  endfunction

endpackage

// File: rtl/code_conv_engine_bcd_digit_adj.sv
// One double-dabble digit correction: digits of 5 or more get +3 before the shift.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/code_conv_engine.sv
// Iterative W-bit converter: bin->gray, bin->BCD, bin->XS3 and gray->bin,
// one conversion in flight, valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// CONV  | gray modes finish in one edge; BCD/XS3 run W double-dabble steps
// ADJ   | XS3 only: +3 on every digit
// DONE  | out_valid high, result held until out_ready
module code_conv_engine
  import code_conv_pkg::*;
#(
  parameter int W  = 8,
  parameter int ND = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic [1:0]      sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*ND-1:0] result,
  output logic [1:0]      mode_out,
  output logic            done
);

  localparam int RW = 4 * ND;
  localparam int CW = (clog2(W) > 0) ? clog2(W) : 1;

  if (W < 2 || bcd_digits(W) > ND || RW < W) begin : g_param_check
    $error("code_conv_engine: ND=%0d cannot hold a %0d-bit operand", ND, W);
  end

  state_e         state, state_nxt;
  mode_e          mode;
  logic [W-1:0]   opnd;
  logic [RW-1:0]  acc, acc_adj, acc_xs3;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   gray_val, bin_val;
  logic [RW+W-1:0] dd_next;
  logic           last_step, gray_mode;

  for (genvar d = 0; d < ND; d++) begin : g_dig
    bcd_digit_adj u_adj (
      .digit (acc[4*d +: 4]),
      .adj   (acc_adj[4*d +: 4])
    );
    // Excess-3 offset is per digit; a carry out of a digit is impossible after BCD.
    assign acc_xs3[4*d +: 4] = acc[4*d +: 4] + 4'd3;
  end

  assign dd_next   = {acc_adj, opnd} << 1;
  assign last_step = (cnt == CW'(W - 1));
  assign gray_mode = (mode == MODE_GRAY) || (mode == MODE_G2B);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign mode_out  = mode;

  always_comb begin
    gray_val = opnd ^ (opnd >> 1);
    bin_val  = '0;
    for (int i = 0; i < W; i++) bin_val[i] = ^(opnd >> i);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CONV;
      CONV: begin
        if (gray_mode)      state_nxt = DONE;
        else if (last_step) state_nxt = (mode == MODE_XS3) ? ADJ : DONE;
      end
      ADJ:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opnd   <= '0;
      mode   <= MODE_GRAY;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state != DONE) && (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd <= in_data;
            mode <= mode_e'(sel);
            acc  <= '0;
            cnt  <= '0;
          end
        end
        CONV: begin
          if (gray_mode) begin
            result <= RW'((mode == MODE_GRAY) ? gray_val : bin_val);
          end else begin
            acc  <= dd_next[RW+W-1:W];
            opnd <= dd_next[W-1:0];
            cnt  <= cnt + CW'(1);
            if (last_step && mode == MODE_BCD) result <= dd_next[RW+W-1:W];
          end
        end
        ADJ: result <= acc_xs3;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_code_conv_engine.sv
// Directed bench for code_conv_engine (W=8/ND=3 plus a W=4/ND=2 instance).
module tb_code_conv_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, done;
  logic [7:0]  in_data;
  logic [1:0]  sel, mode_out;
  logic [11:0] result;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, done4;
  logic [3:0]  in_data4;
  logic [1:0]  sel4, mode_out4;
  logic [7:0]  result4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  code_conv_engine #(.W(8), .ND(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .mode_out(mode_out), .done(done)
  );

  code_conv_engine #(.W(4), .ND(2)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .sel(sel4), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .mode_out(mode_out4), .done(done4)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [11:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one operand and wait for out_valid; leaves the engine in its first DONE cycle.
  task automatic run_conv(input logic [1:0] s, input logic [7:0] d,
                          input logic [11:0] exp, input int lat, input string tag);
    int cyc;
    @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    sel = s; in_data = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; sel = ~s; in_data = ~d;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 40);
    check({tag, " latency"}, 32'(cyc), 32'(lat));
    check({tag, " result"}, 32'(result), 32'(exp));
    check({tag, " mode_out"}, 32'(mode_out), 32'(s));
    check({tag, " done pulse"}, 32'(done), 32'd1);
  endtask

  task automatic take_result(input string tag);
    @(posedge clk); #1;
    check({tag, " done drop"}, 32'(done), 32'd0);
    check({tag, " held"}, 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " released"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int stray;

    vecs[0] = '{2'b00, 8'hB5, 12'h0EF, 1};
    vecs[1] = '{2'b01, 8'd255, 12'h255, 8};
    vecs[2] = '{2'b01, 8'd0, 12'h000, 8};
    vecs[3] = '{2'b10, 8'd93, 12'h3C6, 9};
    vecs[4] = '{2'b11, 8'hEF, 12'h0B5, 1};
    vecs[5] = '{2'b10, 8'd0, 12'h333, 9};
    vecs[6] = '{2'b00, 8'd0, 12'h000, 1};
    vecs[7] = '{2'b11, 8'hFF, 12'h0AA, 1};
    vecs[8] = '{2'b01, 8'd200, 12'h200, 8};
    vecs[9] = '{2'b00, 8'h80, 12'h0C0, 1};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; sel = '0; out_ready = 1'b0;
    in_valid4 = 1'b0; in_data4 = '0; sel4 = '0; out_ready4 = 1'b1;
    #12;
    check("reset outputs", 32'({in_ready, out_valid, done, mode_out, result}),
          32'({1'b1, 1'b0, 1'b0, 2'b00, 12'h000}));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].sel, vecs[i].data, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
      take_result($sformatf("vec%0d", i));
    end

    // Back-to-back with out_ready held high; in_data changes right after the accept.
    @(negedge clk);
    sel = 2'b11; in_data = 8'hEF; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_data = 8'h01;
    @(posedge clk); #1;
    check("b2b first valid", 32'(out_valid), 32'd1);
    check("b2b first result", 32'(result), 32'h0B5);
    @(posedge clk); #1;
    check("b2b transfer", 32'({out_valid, in_ready}), 32'b01);
    @(posedge clk); #1;
    check("b2b second accept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b second result", 32'({out_valid, result}), 32'({1'b1, 12'h001}));
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b second transfer", 32'(out_valid), 32'd0);

    // Backpressure: result held and new operands ignored while DONE.
    run_conv(2'b10, 8'd42, 12'h375, 9, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(i * 37 + 1); sel = 2'b00;
      @(posedge clk); #1;
      check($sformatf("bp hold%0d", i), 32'({out_valid, in_ready, done, mode_out, result}),
            32'({1'b1, 1'b0, 1'b0, 2'b10, 12'h375}));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp transfer", 32'({out_valid, in_ready}), 32'b01);
    stray = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) stray++;
    end
    check("bp no stray accept", 32'(stray), 32'd0);

    // Reset in the 4th CONV cycle of a BCD conversion.
    @(negedge clk);
    sel = 2'b01; in_data = 8'd255; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midop reset outputs", 32'({out_valid, done, mode_out, result}),
          32'({1'b0, 1'b0, 2'b00, 12'h000}));
    @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid || done) stray++;
    end
    check("midop no residual", 32'(stray), 32'd0);
    run_conv(2'b01, 8'd42, 12'h042, 8, "post reset");
    take_result("post reset");

    // W=4, ND=2 instance.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      sel4 = (k == 0) ? 2'b10 : 2'b01;
      in_data4 = (k == 0) ? 4'd15 : 4'd9;
      in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (!out_valid4 && cyc < 40);
      check($sformatf("w4 latency%0d", k), 32'(cyc), (k == 0) ? 32'd5 : 32'd4);
      check($sformatf("w4 result%0d", k), 32'({mode_out4, result4}),
            (k == 0) ? 32'({2'b10, 8'h48}) : 32'({2'b01, 8'h09}));
      @(posedge clk); #1;
      check($sformatf("w4 transfer%0d", k), 32'({out_valid4, in_ready4}), 32'b01);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
